// File: rtl/bldc_pwm_commutator.sv
// bldc_pwm_commutator
//   Six-step BLDC commutator with an 8-bit PWM carrier and per-phase dead time.
//   A divided-clock bit is edge-detected into a PWM tick. The Hall code is
//   synchronized and decoded into a high/low phase pair. Each phase runs a
//   small state machine that holds both of its gates low for DEAD_CYCLES clocks
//   before driving a new level.
//
// Ports
//   clk           system clock
//   rst           synchronous active-high reset
//   tick_src      divided-clock bit; each 0->1 edge is one PWM tick
//   enable        1 = drive gates, 0 = gates off and PWM counter held at 0
//   dir           0 = forward table, 1 = high/low roles swapped
//   duty          requested duty, sampled at each PWM wrap
//   hall          raw Hall sensors {A,B,C}, asynchronous
//   gate_hi       high-side gates {A,B,C}
//   gate_lo       low-side gates {A,B,C}
//   period_start  one-clk pulse after the PWM counter wraps
//   hall_fault    synchronized Hall code is 000 or 111
//
// Phase state | meaning
//   ST_OFF    | both gates off, nothing requested
//   ST_DEAD   | both gates off, counting down before driving dead_tgt
//   ST_DRV_H  | high-side gate on
//   ST_DRV_L  | low-side gate on

module bldc_pwm_commutator #(
    parameter int DEAD_CYCLES = 4,
    parameter int PWM_BITS    = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                tick_src,
    input  logic                enable,
    input  logic                dir,
    input  logic [PWM_BITS-1:0] duty,
    input  logic [2:0]          hall,
    output logic [2:0]          gate_hi,
    output logic [2:0]          gate_lo,
    output logic                period_start,
    output logic                hall_fault
);

    typedef enum logic [1:0] {ST_OFF, ST_DEAD, ST_DRV_H, ST_DRV_L} phase_state_t;
    typedef enum logic [1:0] {WANT_OFF, WANT_H, WANT_L} want_t;

    localparam logic [3:0] DEAD_LOAD = 4'(DEAD_CYCLES);

    logic                tick_src_d;
    logic                tick;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic [PWM_BITS-1:0] duty_q;
    logic                pwm_on;
    logic [2:0]          hall_meta;
    logic [2:0]          hall_s;
    logic [1:0]          fill_cnt;
    logic [2:0]          hi_sel;
    logic [2:0]          lo_sel;
    logic [2:0]          hi_ph;
    logic [2:0]          lo_ph;
    want_t               want         [3];
    phase_state_t        state        [3];
    phase_state_t        state_nxt    [3];
    logic [3:0]          dead_cnt     [3];
    logic [3:0]          dead_cnt_nxt [3];
    want_t               dead_tgt     [3];
    want_t               dead_tgt_nxt [3];

    assign tick   = tick_src & ~tick_src_d;
    assign pwm_on = pwm_cnt < duty_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            tick_src_d   <= 1'b0;
            pwm_cnt      <= '0;
            duty_q       <= '0;
            period_start <= 1'b0;
        end else begin
            tick_src_d   <= tick_src;
            period_start <= 1'b0;
            if (!enable) begin
                pwm_cnt <= '0;
            end else if (tick) begin
                pwm_cnt <= pwm_cnt + PWM_BITS'(1);
                // New duty only takes effect at a period boundary.
                if (pwm_cnt == '1) begin
                    duty_q       <= duty;
                    period_start <= 1'b1;
                end
            end
        end
    end

    // fill_cnt masks hall_fault while the synchronizer still holds reset zeros.
    always_ff @(posedge clk) begin
        if (rst) begin
            hall_meta  <= 3'b000;
            hall_s     <= 3'b000;
            fill_cnt   <= 2'd3;
            hall_fault <= 1'b0;
        end else begin
            hall_meta  <= hall;
            hall_s     <= hall_meta;
            if (fill_cnt != 2'd0) begin
                fill_cnt <= fill_cnt - 2'd1;
            end
            hall_fault <= (fill_cnt == 2'd0) && ((hall_s == 3'b000) || (hall_s == 3'b111));
        end
    end

    // One-hot phase selects, bit 2 = A, bit 0 = C.
    always_comb begin
        hi_sel = 3'b000;
        lo_sel = 3'b000;
        case (hall_s)
            3'b101:  begin hi_sel = 3'b100; lo_sel = 3'b010; end
            3'b100:  begin hi_sel = 3'b100; lo_sel = 3'b001; end
            3'b110:  begin hi_sel = 3'b010; lo_sel = 3'b001; end
            3'b010:  begin hi_sel = 3'b010; lo_sel = 3'b100; end
            3'b011:  begin hi_sel = 3'b001; lo_sel = 3'b100; end
            3'b001:  begin hi_sel = 3'b001; lo_sel = 3'b010; end
            default: begin hi_sel = 3'b000; lo_sel = 3'b000; end
        endcase
    end

    assign hi_ph = dir ? lo_sel : hi_sel;
    assign lo_ph = dir ? hi_sel : lo_sel;

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            want[i] = WANT_OFF;
            if (enable && !hall_fault) begin
                if (lo_ph[i]) begin
                    want[i] = WANT_L;
                end else if (hi_ph[i] && pwm_on) begin
                    want[i] = WANT_H;
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            state_nxt[i]    = state[i];
            dead_cnt_nxt[i] = dead_cnt[i];
            dead_tgt_nxt[i] = dead_tgt[i];
            if (want[i] == WANT_OFF) begin
                // Turn-off is never delayed.
                state_nxt[i]    = ST_OFF;
                dead_cnt_nxt[i] = '0;
                dead_tgt_nxt[i] = WANT_OFF;
            end else begin
                case (state[i])
                    ST_DEAD: begin
                        if (want[i] != dead_tgt[i]) begin
                            dead_cnt_nxt[i] = DEAD_LOAD;
                            dead_tgt_nxt[i] = want[i];
                        end else if (dead_cnt[i] <= 4'd1) begin
                            state_nxt[i]    = (want[i] == WANT_H) ? ST_DRV_H : ST_DRV_L;
                            dead_cnt_nxt[i] = '0;
                        end else begin
                            dead_cnt_nxt[i] = dead_cnt[i] - 4'd1;
                        end
                    end
                    ST_DRV_H: begin
                        if (want[i] != WANT_H) begin
                            state_nxt[i]    = ST_DEAD;
                            dead_cnt_nxt[i] = DEAD_LOAD;
                            dead_tgt_nxt[i] = want[i];
                        end
                    end
                    ST_DRV_L: begin
                        if (want[i] != WANT_L) begin
                            state_nxt[i]    = ST_DEAD;
                            dead_cnt_nxt[i] = DEAD_LOAD;
                            dead_tgt_nxt[i] = want[i];
                        end
                    end
                    default: begin
                        state_nxt[i]    = ST_DEAD;
                        dead_cnt_nxt[i] = DEAD_LOAD;
                        dead_tgt_nxt[i] = want[i];
                    end
                endcase
            end
        end
    end

    // Gates share the state register's next value so they never lag the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 3; i++) begin
                state[i]    <= ST_OFF;
                dead_cnt[i] <= '0;
                dead_tgt[i] <= WANT_OFF;
            end
            gate_hi <= 3'b000;
            gate_lo <= 3'b000;
        end else begin
            for (int i = 0; i < 3; i++) begin
                state[i]    <= state_nxt[i];
                dead_cnt[i] <= dead_cnt_nxt[i];
                dead_tgt[i] <= dead_tgt_nxt[i];
                gate_hi[i]  <= (state_nxt[i] == ST_DRV_H);
                gate_lo[i]  <= (state_nxt[i] == ST_DRV_L);
            end
        end
    end

endmodule

// File: tb/tb_bldc_pwm_commutator.sv
module tb_bldc_pwm_commutator;

    localparam int DEAD = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       tick_src;
    logic       enable;
    logic       dir;
    logic [7:0] duty;
    logic [2:0] hall;
    logic [2:0] gate_hi;
    logic [2:0] gate_lo;
    logic       period_start;
    logic       hall_fault;

    bldc_pwm_commutator #(.DEAD_CYCLES(DEAD), .PWM_BITS(8)) dut (
        .clk(clk), .rst(rst), .tick_src(tick_src), .enable(enable), .dir(dir),
        .duty(duty), .hall(hall), .gate_hi(gate_hi), .gate_lo(gate_lo),
        .period_start(period_start), .hall_fault(hall_fault)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int tick_mode = 0;
    int divc = 0;
    bit mon_en = 0;

    // Reference model: spec rules in plain arithmetic.
    // Phase p: 0=A,1=B,2=C -> vector bit 2-p. Desired/out code: 0=off,1=high,2=low.
    int m_cnt = 0, m_duty = 0, m_hm = 0, m_hs = 0, m_since = 0;
    bit m_src_d = 0, m_fault = 0, m_ps = 0, m_tick;
    int m_out[3] = '{0, 0, 0};
    int m_run[3] = '{0, 0, 0};
    int m_last[3] = '{0, 0, 0};
    int m_des[3];
    int m_h, m_l;
    int hi_of[8] = '{-1, 2, 1, 2, 0, 0, 1, -1};
    int lo_of[8] = '{-1, 1, 0, 0, 2, 1, 2, -1};

    always @(posedge clk) begin
        if (rst) begin
            m_cnt = 0; m_duty = 0; m_hm = 0; m_hs = 0; m_since = 0;
            m_src_d = 0; m_fault = 0; m_ps = 0;
            for (int p = 0; p < 3; p++) begin m_out[p] = 0; m_run[p] = 0; m_last[p] = 0; end
        end else begin
            for (int p = 0; p < 3; p++) m_des[p] = 0;
            if (enable && !m_fault && hi_of[m_hs] >= 0) begin
                m_h = dir ? lo_of[m_hs] : hi_of[m_hs];
                m_l = dir ? hi_of[m_hs] : lo_of[m_hs];
                m_des[m_l] = 2;
                if (m_cnt < m_duty) m_des[m_h] = 1;
            end
            // A level is driven once it has been requested for more than DEAD edges in a row.
            for (int p = 0; p < 3; p++) begin
                if (m_des[p] == 0) begin
                    m_out[p] = 0; m_run[p] = 0; m_last[p] = 0;
                end else begin
                    m_run[p] = (m_des[p] == m_last[p]) ? m_run[p] + 1 : 1;
                    m_last[p] = m_des[p];
                    if (m_out[p] != m_des[p]) m_out[p] = (m_run[p] > DEAD) ? m_des[p] : 0;
                end
            end
            m_tick = tick_src && !m_src_d;
            m_src_d = tick_src;
            m_ps = 0;
            if (!enable) m_cnt = 0;
            else if (m_tick) begin
                if (m_cnt == 255) begin m_duty = duty; m_ps = 1; end
                m_cnt = (m_cnt + 1) % 256;
            end
            if (m_since < 4) m_since++;
            m_fault = (m_since >= 4) && (m_hs == 0 || m_hs == 7);
            m_hs = m_hm;
            m_hm = hall;
        end
    end

    // Every-cycle monitor: model agreement, no shoot-through, dead time before any turn-on.
    logic [2:0] eh, el, prev_hi = 3'b000, prev_lo = 3'b000;
    int zrun[3] = '{0, 0, 0};

    always @(negedge clk) begin
        if (mon_en) begin
            for (int p = 0; p < 3; p++) begin
                eh[2-p] = (m_out[p] == 1);
                el[2-p] = (m_out[p] == 2);
            end
            n_checks++;
            if (gate_hi !== eh) begin n_fail++; $display("FAIL model_gate_hi t=%0t got %b exp %b", $time, gate_hi, eh); end
            n_checks++;
            if (gate_lo !== el) begin n_fail++; $display("FAIL model_gate_lo t=%0t got %b exp %b", $time, gate_lo, el); end
            n_checks++;
            if (period_start !== m_ps) begin n_fail++; $display("FAIL model_period_start t=%0t got %b exp %b", $time, period_start, m_ps); end
            n_checks++;
            if (hall_fault !== m_fault) begin n_fail++; $display("FAIL model_hall_fault t=%0t got %b exp %b", $time, hall_fault, m_fault); end
            for (int i = 0; i < 3; i++) begin
                n_checks++;
                if (gate_hi[i] & gate_lo[i]) begin
                    n_fail++; $display("FAIL shoot_through t=%0t phase_bit %0d hi %b lo %b", $time, i, gate_hi, gate_lo);
                end
                if ((gate_hi[i] && !prev_hi[i]) || (gate_lo[i] && !prev_lo[i])) begin
                    n_checks++;
                    if (zrun[i] < DEAD) begin
                        n_fail++; $display("FAIL dead_time t=%0t phase_bit %0d got %0d off cycles need %0d", $time, i, zrun[i], DEAD);
                    end
                end
                if (!gate_hi[i] && !gate_lo[i]) zrun[i]++;
                else zrun[i] = 0;
            end
            prev_hi = gate_hi;
            prev_lo = gate_lo;
        end
    end

    task automatic step();
        @(negedge clk);
        if (tick_mode == 0) begin
            divc++;
            tick_src = divc[1];
        end else begin
            tick_src = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic wait_ps(output bit ok);
        ok = 0;
        for (int i = 0; i < 1200; i++) begin
            step();
            if (period_start) begin ok = 1; break; end
        end
    endtask

    task automatic test_reset();
        rst = 1; enable = 0; dir = 0; duty = 8'd0; hall = 3'b000; tick_src = 0;
        tick_mode = 0; divc = 0; mon_en = 1;
        repeat (3) begin
            step();
            n_checks++;
            if ({gate_hi, gate_lo, period_start, hall_fault} !== 8'h00) begin
                n_fail++; $display("FAIL reset_outputs got %b%b%b%b exp all zero", gate_hi, gate_lo, period_start, hall_fault);
            end
        end
        rst = 0; hall = 3'b101; enable = 1; duty = 8'd0;
        for (int k = 1; k <= 8; k++) begin
            step();
            if (k <= 3) begin
                n_checks++;
                if (hall_fault !== 1'b0) begin n_fail++; $display("FAIL fault_mask k=%0d got %b exp 0", k, hall_fault); end
            end
            if (k == DEAD + 2) begin
                n_checks++;
                if (gate_lo !== 3'b000) begin n_fail++; $display("FAIL startup_lo_early got %b exp 000", gate_lo); end
            end
            if (k == DEAD + 3) begin
                n_checks++;
                if (gate_lo !== 3'b010) begin n_fail++; $display("FAIL startup_lo_on got %b exp 010", gate_lo); end
            end
            n_checks++;
            if (gate_hi !== 3'b000) begin n_fail++; $display("FAIL startup_hi k=%0d got %b exp 000", k, gate_hi); end
        end
    endtask

    task automatic test_pwm_duty();
        bit ok;
        int d, hi_cnt, ps_cnt, lo_bad;
        for (int r = 0; r < 3; r++) begin
            d = (r == 0) ? 64 : int'($urandom_range(1, 255));
            duty = 8'(d);
            wait_ps(ok);
            n_checks++;
            if (!ok) begin n_fail++; $display("FAIL pwm_wait_wrap got timeout exp period_start"); end
            hi_cnt = 0; ps_cnt = 0; lo_bad = 0;
            for (int i = 1; i <= 1024; i++) begin
                step();
                hi_cnt += int'(gate_hi[2]);
                ps_cnt += int'(period_start);
                if (gate_lo !== 3'b010) lo_bad++;
            end
            n_checks++;
            if (hi_cnt !== 4 * d - DEAD) begin n_fail++; $display("FAIL pwm_on_time duty %0d got %0d exp %0d", d, hi_cnt, 4 * d - DEAD); end
            n_checks++;
            if (ps_cnt !== 1) begin n_fail++; $display("FAIL pwm_period_pulses got %0d exp 1", ps_cnt); end
            n_checks++;
            if (lo_bad !== 0) begin n_fail++; $display("FAIL pwm_low_steady got %0d bad cycles exp 0", lo_bad); end
        end
    endtask

    task automatic test_hall_step();
        duty = 8'd128;
        hall = 3'b100;
        for (int k = 1; k <= 8; k++) begin
            step();
            if (k == 2) begin
                n_checks++;
                if (gate_lo[1] !== 1'b1) begin n_fail++; $display("FAIL step_b_held got %b exp 1", gate_lo[1]); end
            end
            if (k == 4) begin
                n_checks++;
                if (gate_lo[1] !== 1'b0) begin n_fail++; $display("FAIL step_b_drop got %b exp 0", gate_lo[1]); end
            end
            if (k == DEAD + 2) begin
                n_checks++;
                if (gate_lo[0] !== 1'b0) begin n_fail++; $display("FAIL step_c_early got %b exp 0", gate_lo[0]); end
            end
            if (k == DEAD + 3) begin
                n_checks++;
                if (gate_lo !== 3'b001) begin n_fail++; $display("FAIL step_c_on got %b exp 001", gate_lo); end
            end
        end
        repeat (300) step();
    endtask

    task automatic test_dir();
        int lo_bad, hi_b, hi_other;
        logic [2:0] codes [6] = '{3'b101, 3'b100, 3'b110, 3'b010, 3'b011, 3'b001};
        dir = 1; hall = 3'b101; duty = 8'd128;
        lo_bad = 0; hi_b = 0; hi_other = 0;
        for (int k = 1; k <= 2100; k++) begin
            step();
            if (k > DEAD + 1 && gate_lo !== 3'b100) lo_bad++;
            hi_b += int'(gate_hi[1]);
            hi_other += int'(gate_hi[2]) + int'(gate_hi[0]);
        end
        n_checks++;
        if (lo_bad !== 0) begin n_fail++; $display("FAIL rev_low_a got %0d bad cycles exp 0", lo_bad); end
        n_checks++;
        if (hi_b < 4 * 128 - DEAD) begin n_fail++; $display("FAIL rev_high_b got %0d on cycles exp at least %0d", hi_b, 4 * 128 - DEAD); end
        n_checks++;
        if (hi_other !== 0) begin n_fail++; $display("FAIL rev_high_other got %0d exp 0", hi_other); end
        for (int k = 0; k < 800; k++) begin
            step();
            if ($urandom_range(0, 15) == 0) dir = ~dir;
            if ($urandom_range(0, 39) == 0) hall = codes[$urandom_range(0, 5)];
        end
        dir = 0;
    endtask

    task automatic test_fault();
        logic [2:0] bad [2] = '{3'b000, 3'b111};
        duty = 8'd128;
        for (int b = 0; b < 2; b++) begin
            hall = 3'b101;
            repeat (20) step();
            hall = bad[b];
            for (int k = 1; k <= 4; k++) begin
                step();
                if (k == 2) begin
                    n_checks++;
                    if (hall_fault !== 1'b0) begin n_fail++; $display("FAIL fault_early code %b got %b exp 0", bad[b], hall_fault); end
                end
                if (k == 3) begin
                    n_checks++;
                    if (hall_fault !== 1'b1) begin n_fail++; $display("FAIL fault_set code %b got %b exp 1", bad[b], hall_fault); end
                end
                if (k == 4) begin
                    n_checks++;
                    if ({gate_hi, gate_lo} !== 6'b0) begin n_fail++; $display("FAIL fault_gates_off got %b %b exp 000 000", gate_hi, gate_lo); end
                end
            end
        end
        hall = 3'b110;
        for (int k = 1; k <= DEAD + 4; k++) begin
            step();
            if (k == 3) begin
                n_checks++;
                if (hall_fault !== 1'b0) begin n_fail++; $display("FAIL fault_clear got %b exp 0", hall_fault); end
            end
            if (k == DEAD + 3) begin
                n_checks++;
                if (gate_lo !== 3'b000) begin n_fail++; $display("FAIL resume_lo_early got %b exp 000", gate_lo); end
            end
            if (k == DEAD + 4) begin
                n_checks++;
                if (gate_lo !== 3'b001) begin n_fail++; $display("FAIL resume_lo_c got %b exp 001", gate_lo); end
            end
        end
        begin
            int hb;
            hb = 0;
            repeat (1100) begin step(); hb += int'(gate_hi[1]); end
            n_checks++;
            if (hb == 0) begin n_fail++; $display("FAIL resume_hi_b got 0 on cycles exp nonzero"); end
        end
    endtask

    task automatic test_duty_change_and_rst();
        bit ok;
        int hi_cnt, ps_cnt;
        hall = 3'b101; duty = 8'd50;
        wait_ps(ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL dc_wait1 got timeout exp period_start"); end
        wait_ps(ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL dc_wait2 got timeout exp period_start"); end
        for (int w = 0; w < 2; w++) begin
            hi_cnt = 0; ps_cnt = 0;
            for (int i = 1; i <= 1024; i++) begin
                step();
                if (w == 0 && i == 400) duty = 8'd200;
                hi_cnt += int'(gate_hi[2]);
                ps_cnt += int'(period_start);
            end
            n_checks++;
            if (hi_cnt !== ((w == 0) ? 4 * 50 - DEAD : 4 * 200 - DEAD)) begin
                n_fail++; $display("FAIL dc_on_time window %0d got %0d exp %0d", w, hi_cnt, (w == 0) ? 4 * 50 - DEAD : 4 * 200 - DEAD);
            end
            n_checks++;
            if (ps_cnt !== 1) begin n_fail++; $display("FAIL dc_period_pulses window %0d got %0d exp 1", w, ps_cnt); end
        end
        repeat (300) step();
        rst = 1;
        step();
        n_checks++;
        if ({gate_hi, gate_lo, period_start, hall_fault} !== 8'h00) begin
            n_fail++; $display("FAIL mid_rst got %b %b %b %b exp all zero", gate_hi, gate_lo, period_start, hall_fault);
        end
        rst = 0;
        repeat (100) step();
    endtask

    task automatic test_random();
        tick_mode = 1;
        for (int k = 0; k < 3000; k++) begin
            step();
            rst = 0;
            if ($urandom_range(0, 19) == 0) hall = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 49) == 0) dir = ~dir;
            if ($urandom_range(0, 29) == 0) duty = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 99) == 0) enable = ~enable;
            if ($urandom_range(0, 499) == 0) rst = 1;
        end
        rst = 0; enable = 0;
        step();
        step();
        n_checks++;
        if ({gate_hi, gate_lo} !== 6'b0) begin n_fail++; $display("FAIL disable_gates got %b %b exp 000 000", gate_hi, gate_lo); end
        n_checks++;
        if (period_start !== 1'b0) begin n_fail++; $display("FAIL disable_period got %b exp 0", period_start); end
    endtask

    initial begin
        test_reset();
        test_pwm_duty();
        test_hall_step();
        test_dir();
        test_fault();
        test_duty_change_and_rst();
        test_random();
        @(posedge clk);
        mon_en = 0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
